// File: rtl/t05_digit_scanner.sv
// t05_digit_scanner: four-digit multiplexed hex display scanner.
// Steps a one-hot select across four digits, PRESCALE cycles each.
// The displayed word is double-buffered so a new value only takes
// effect at a frame boundary. Leading zeros can be blanked.
module t05_digit_scanner #(
  parameter int PRESCALE = 1000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        disp_on,
  input  logic        blank_lz,
  output logic [3:0]  digit_nibble,
  output logic        digit_en,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0]   r_pcnt;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_active;
  logic [3:0][3:0] r_pend;
  logic            r_pend_valid;
  logic            r_disp_on;
  logic            r_blank_lz;
  logic            r_frame_done;

  logic            w_wrap;
  logic            w_boundary;
  logic [3:0]      w_lz;

  assign w_wrap     = (r_pcnt == PLAST);
  assign w_boundary = w_wrap && (r_idx == 2'd3);

  // Prescale counter and digit index; idx steps on the cycle pcnt wraps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else begin
      r_pcnt <= w_wrap ? '0 : r_pcnt + 1'b1;
      if (w_wrap) r_idx <= r_idx + 1'b1;
    end
  end

  // Double buffer: a load on the boundary bypasses (and drops) the pending
  // word; otherwise the pending word is promoted at the boundary.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_active     <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
    end else if (load && w_boundary) begin
      r_active     <= value;
      r_pend_valid <= 1'b0;
    end else if (load) begin
      r_pend       <= value;
      r_pend_valid <= 1'b1;
    end else if (w_boundary && r_pend_valid) begin
      r_active     <= r_pend;
      r_pend_valid <= 1'b0;
    end
  end

  // Register control inputs and the frame-done pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_disp_on    <= 1'b0;
      r_blank_lz   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_disp_on    <= disp_on;
      r_blank_lz   <= blank_lz;
      r_frame_done <= w_boundary;
    end
  end

  // Leading-zero flags: digit i is a leading zero when it and every
  // higher digit are zero; digit 0 always shows.
  always_comb begin
    w_lz    = '0;
    w_lz[3] = (r_active[3] == 4'h0);
    w_lz[2] = w_lz[3] && (r_active[2] == 4'h0);
    w_lz[1] = w_lz[2] && (r_active[1] == 4'h0);
  end

  // Outputs decode registered state only, so they are glitch-free per digit.
  always_comb begin
    digit_sel    = 4'b0001 << r_idx;
    digit_nibble = r_active[r_idx];
    digit_en     = r_disp_on && !(r_blank_lz && w_lz[r_idx]);
    frame_done   = r_frame_done;
  end

endmodule
